// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: falling-edge T1..T6 ring counter, halt latch and combinational control-word decode.
// Optional build macro VARIABLE_MACHINE_CYCLE_EN shortens LDA, OUT and undefined opcodes by returning early to T1.
module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] instruction,
    output logic [5:0] T_state,
    output logic       C_P,
    output logic       E_P,
    output logic       L_M_bar,
    output logic       C_E_bar,
    output logic       L_I_bar,
    output logic       E_I_bar,
    output logic       L_A_bar,
    output logic       E_A,
    output logic       S_U,
    output logic       E_U,
    output logic       L_B_bar,
    output logic       L_O_bar,
    output logic       HLT
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    state_t state_q, state_d;
    logic   hlt_q, hlt_d;
    logic   is_lda, is_add, is_sub, is_out, is_hlt;

    assign is_lda = (instruction == OP_LDA);
    assign is_add = (instruction == OP_ADD);
    assign is_sub = (instruction == OP_SUB);
    assign is_out = (instruction == OP_OUT);
    assign is_hlt = (instruction == OP_HLT);

    // Falling-edge update keeps the decoded word stable around the rising edge the datapath uses.
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= T1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hlt_q   <= hlt_d;
        end
    end

    always_comb begin
        hlt_d = hlt_q;
        case (state_q)
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = T4;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = T1;
            default: state_d = T1;
        endcase
        if (hlt_q) begin
            state_d = state_q;
        end else if (state_q == T4 && is_hlt) begin
            hlt_d   = 1'b1;
            state_d = T4;
        end
`ifdef VARIABLE_MACHINE_CYCLE_EN
        else if (state_q == T4 && !(is_lda || is_add || is_sub)) begin
            state_d = T1;
        end else if (state_q == T5 && is_lda) begin
            state_d = T1;
        end
`endif
    end

    always_comb begin
        C_P     = 1'b0;
        E_P     = 1'b0;
        L_M_bar = 1'b1;
        C_E_bar = 1'b1;
        L_I_bar = 1'b1;
        E_I_bar = 1'b1;
        L_A_bar = 1'b1;
        E_A     = 1'b0;
        S_U     = 1'b0;
        E_U     = 1'b0;
        L_B_bar = 1'b1;
        L_O_bar = 1'b1;
        if (!hlt_q) begin
            case (state_q)
                T1: begin
                    E_P     = 1'b1;
                    L_M_bar = 1'b0;
                end
                T2: C_P = 1'b1;
                T3: begin
                    C_E_bar = 1'b0;
                    L_I_bar = 1'b0;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        E_I_bar = 1'b0;
                        L_M_bar = 1'b0;
                    end else if (is_out) begin
                        E_A     = 1'b1;
                        L_O_bar = 1'b0;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        C_E_bar = 1'b0;
                        L_A_bar = 1'b0;
                    end else if (is_add || is_sub) begin
                        C_E_bar = 1'b0;
                        L_B_bar = 1'b0;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        E_U     = 1'b1;
                        S_U     = is_sub;
                        L_A_bar = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign T_state = state_q;
    assign HLT     = hlt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: expected ring/word/HLT pushed per step, popped after each falling edge.
module tb_controller_sequencer;

    logic       CLK;
    logic       CLR;
    logic [3:0] instruction;
    logic [5:0] T_state;
    logic C_P, E_P, L_M_bar, C_E_bar, L_I_bar, E_I_bar;
    logic L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar, HLT;
    logic [11:0] word;

    typedef struct packed {
        logic [5:0]  t;
        logic [11:0] w;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [11:0] W_IDLE = 12'h3E3;

    controller_sequencer dut (
        .CLK(CLK), .CLR(CLR), .instruction(instruction), .T_state(T_state),
        .C_P(C_P), .E_P(E_P), .L_M_bar(L_M_bar), .C_E_bar(C_E_bar),
        .L_I_bar(L_I_bar), .E_I_bar(E_I_bar), .L_A_bar(L_A_bar), .E_A(E_A),
        .S_U(S_U), .E_U(E_U), .L_B_bar(L_B_bar), .L_O_bar(L_O_bar), .HLT(HLT)
    );

    assign word = {C_P, E_P, L_M_bar, C_E_bar, L_I_bar, E_I_bar,
                   L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar};

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    // Expected control words, packed {C_P,E_P,L_M_bar,C_E_bar,L_I_bar,E_I_bar,L_A_bar,E_A,S_U,E_U,L_B_bar,L_O_bar}
    function automatic logic [11:0] ref_word(input int ti, input logic [3:0] op);
        case (ti)
            0: return 12'h5E3;
            1: return 12'hBE3;
            2: return 12'h263;
            3: return (op == 4'h0 || op == 4'h1 || op == 4'h2) ? 12'h1A3 :
                      (op == 4'hE) ? 12'h3F2 : W_IDLE;
            4: return (op == 4'h0) ? 12'h2C3 :
                      (op == 4'h1 || op == 4'h2) ? 12'h2E1 : W_IDLE;
            5: return (op == 4'h1) ? 12'h3C7 : (op == 4'h2) ? 12'h3CF : W_IDLE;
            default: return W_IDLE;
        endcase
    endfunction

    function automatic int cyc_len(input logic [3:0] op);
`ifdef VARIABLE_MACHINE_CYCLE_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
`else
        return 6 + 0 * op;
`endif
    endfunction

    task automatic pulse_clr();
        @(posedge CLK);
        #1 CLR = 1'b1;
        #2 CLR = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        instruction = 4'h0;
        @(posedge CLK);
        #1 CLR = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{t: 6'b000001, w: 12'h5E3, h: 1'b0});
            if (k > 0) begin
                @(negedge CLK);
                #3;
            end
            e = sb.pop_front();
            n_checks += 3;
            if (T_state !== e.t) begin
                n_fail++;
                $display("FAIL reset[%0d] T_state: got %b expected %b", k, T_state, e.t);
            end
            if (word !== e.w) begin
                n_fail++;
                $display("FAIL reset[%0d] word: got %h expected %h", k, word, e.w);
            end
            if (HLT !== e.h) begin
                n_fail++;
                $display("FAIL reset[%0d] HLT: got %b expected %b", k, HLT, e.h);
            end
        end
        CLR = 1'b0;
    endtask

    task automatic test_instruction_cycle(input logic [3:0] op, input string nm);
        exp_t e;
        int   len;
        int   ti;
        instruction = op;
        pulse_clr();
        len = cyc_len(op);
        for (int k = 0; k <= len; k++) begin
            ti = k % len;
            sb.push_back('{t: 6'(1 << ti), w: ref_word(ti, op), h: 1'b0});
            if (k > 0) begin
                @(negedge CLK);
                #3;
            end
            e = sb.pop_front();
            n_checks += 3;
            if (T_state !== e.t) begin
                n_fail++;
                $display("FAIL %s step%0d T_state: got %b expected %b", nm, k, T_state, e.t);
            end
            if (word !== e.w) begin
                n_fail++;
                $display("FAIL %s step%0d word: got %h expected %h", nm, k, word, e.w);
            end
            if (HLT !== e.h) begin
                n_fail++;
                $display("FAIL %s step%0d HLT: got %b expected %b", nm, k, HLT, e.h);
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        instruction = 4'hF;
        pulse_clr();
        for (int k = 0; k <= 14; k++) begin
            if (k <= 3) sb.push_back('{t: 6'(1 << k), w: ref_word(k, 4'hF), h: 1'b0});
            else        sb.push_back('{t: 6'b001000, w: W_IDLE, h: 1'b1});
            if (k > 0) begin
                @(negedge CLK);
                #3;
            end
            e = sb.pop_front();
            n_checks += 3;
            if (T_state !== e.t) begin
                n_fail++;
                $display("FAIL halt step%0d T_state: got %b expected %b", k, T_state, e.t);
            end
            if (word !== e.w) begin
                n_fail++;
                $display("FAIL halt step%0d word: got %h expected %h", k, word, e.w);
            end
            if (HLT !== e.h) begin
                n_fail++;
                $display("FAIL halt step%0d HLT: got %b expected %b", k, HLT, e.h);
            end
        end
        sb.push_back('{t: 6'b000001, w: 12'h5E3, h: 1'b0});
        CLR = 1'b1;
        #1;
        e = sb.pop_front();
        n_checks += 3;
        if (T_state !== e.t) begin
            n_fail++;
            $display("FAIL halt_clr T_state: got %b expected %b", T_state, e.t);
        end
        if (word !== e.w) begin
            n_fail++;
            $display("FAIL halt_clr word: got %h expected %h", word, e.w);
        end
        if (HLT !== e.h) begin
            n_fail++;
            $display("FAIL halt_clr HLT: got %b expected %b", HLT, e.h);
        end
        CLR = 1'b0;
    endtask

    task automatic test_clr_mid();
        exp_t e;
        instruction = 4'h1;
        pulse_clr();
        repeat (4) @(negedge CLK);
        #3;
        sb.push_back('{t: 6'b010000, w: 12'h2E1, h: 1'b0});
        e = sb.pop_front();
        n_checks++;
        if (T_state !== e.t || word !== e.w) begin
            n_fail++;
            $display("FAIL clr_mid_pre state/word: got %b/%h expected %b/%h", T_state, word, e.t, e.w);
        end
        sb.push_back('{t: 6'b000001, w: 12'h5E3, h: 1'b0});
        CLR = 1'b1;
        #1;
        e = sb.pop_front();
        n_checks += 3;
        if (T_state !== e.t) begin
            n_fail++;
            $display("FAIL clr_mid T_state: got %b expected %b", T_state, e.t);
        end
        if (word !== e.w) begin
            n_fail++;
            $display("FAIL clr_mid word: got %h expected %h", word, e.w);
        end
        if (HLT !== e.h) begin
            n_fail++;
            $display("FAIL clr_mid HLT: got %b expected %b", HLT, e.h);
        end
        CLR = 1'b0;
    endtask

    // ADD then SUB with no reset between; HLT opcode shown only during fetch must not halt.
    task automatic test_back_to_back();
        exp_t e;
        int   ti;
        instruction = 4'h1;
        pulse_clr();
        for (int k = 0; k <= 12; k++) begin
            ti = k % 6;
            sb.push_back('{t: 6'(1 << ti), w: ref_word(ti, (k < 6) ? 4'h1 : 4'h2), h: 1'b0});
            if (k > 0) begin
                @(negedge CLK);
                #3;
            end
            e = sb.pop_front();
            n_checks += 3;
            if (T_state !== e.t) begin
                n_fail++;
                $display("FAIL b2b step%0d T_state: got %b expected %b", k, T_state, e.t);
            end
            if (word !== e.w) begin
                n_fail++;
                $display("FAIL b2b step%0d word: got %h expected %h", k, word, e.w);
            end
            if (HLT !== e.h) begin
                n_fail++;
                $display("FAIL b2b step%0d HLT: got %b expected %b", k, HLT, e.h);
            end
            if (k == 5) instruction = 4'hF;
            if (k == 7) instruction = 4'h2;
        end
    endtask

    initial begin
        CLR         = 1'b0;
        instruction = 4'h0;
        test_reset();
        test_instruction_cycle(4'h0, "lda");
        test_instruction_cycle(4'h1, "add");
        test_instruction_cycle(4'h2, "sub");
        test_instruction_cycle(4'hE, "out");
        test_instruction_cycle(4'h7, "undef");
        test_halt();
        test_clr_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
